// File: rtl/image_buffer.sv
// rtl/image_buffer.sv - dual-port image buffer with a hardware clear sequencer
// Optional write-collision flag port COLL: define IMAGE_BUFFER_COLL_FLAG_EN.
module image_buffer #(
    parameter int A_W = 5,
    parameter int D_W = 1
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [A_W-1:0] A_0,
    input  logic [D_W-1:0] DI_0,
    input  logic           WE_0,
    output logic [D_W-1:0] DQ_0,
    input  logic [A_W-1:0] A_1,
    input  logic [D_W-1:0] DI_1,
    input  logic           WE_1,
    output logic [D_W-1:0] DQ_1,
    input  logic           CLR,
`ifdef IMAGE_BUFFER_COLL_FLAG_EN
    output logic           COLL,
`endif
    output logic           RDY
);
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [A_W-1:0] clr_cnt;
    logic [D_W-1:0] mem [0:(2**A_W)-1];
    logic           acc;
    logic           same_addr;
    logic           wr0;
    logic           wr1;
    logic [A_W-1:0] wa0;
    logic [D_W-1:0] wd0;

    // Reset lands in CLEAR so the array is zeroed before the first access.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + A_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (CLR) state_nxt = CLEAR;
            CLEAR:   if (&clr_cnt) state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    // The clear sequencer borrows the port-0 write path.
    always_comb begin
        RDY       = (state == IDLE);
        acc       = (state == IDLE) && !CLR;
        same_addr = (A_0 == A_1);
        wr0       = acc && WE_0;
        wr1       = acc && WE_1 && !(WE_0 && same_addr);
        wa0       = A_0;
        wd0       = DI_0;
        if (state == CLEAR) begin
            wr0 = 1'b1;
            wa0 = clr_cnt;
            wd0 = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr0) begin
            mem[wa0] <= wd0;
        end
        if (wr1) begin
            mem[A_1] <= DI_1;
        end
    end

    // Read data is forced to zero from the CLR edge until the clear completes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DQ_0 <= '0;
            DQ_1 <= '0;
        end else if (acc) begin
            DQ_0 <= mem[A_0];
            DQ_1 <= mem[A_1];
        end else begin
            DQ_0 <= '0;
            DQ_1 <= '0;
        end
    end

`ifdef IMAGE_BUFFER_COLL_FLAG_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            COLL <= 1'b0;
        end else begin
            COLL <= acc && WE_0 && WE_1 && same_addr;
        end
    end
`endif

endmodule

// File: tb/tb_image_buffer.sv
// tb/tb_image_buffer.sv - scoreboard bench for image_buffer
module tb_image_buffer;
    localparam int AW    = 5;
    localparam int DW    = 1;
    localparam int DEPTH = 32;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          RST_N;
    logic [AW-1:0] A_0, A_1;
    logic [DW-1:0] DI_0, DI_1, DQ_0, DQ_1;
    logic          WE_0, WE_1, CLR, RDY;
`ifdef IMAGE_BUFFER_COLL_FLAG_EN
    logic          COLL, coll8;
`endif

    logic       rst8, we80, we81, clr8, rdy8;
    logic [7:0] a80, a81, di80, di81, dq80, dq81;

    image_buffer #(.A_W(AW), .D_W(DW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .A_0(A_0), .DI_0(DI_0), .WE_0(WE_0), .DQ_0(DQ_0),
        .A_1(A_1), .DI_1(DI_1), .WE_1(WE_1), .DQ_1(DQ_1),
        .CLR(CLR),
`ifdef IMAGE_BUFFER_COLL_FLAG_EN
        .COLL(COLL),
`endif
        .RDY(RDY)
    );

    image_buffer #(.A_W(8), .D_W(8)) dut8 (
        .CLK(CLK), .RST_N(rst8),
        .A_0(a80), .DI_0(di80), .WE_0(we80), .DQ_0(dq80),
        .A_1(a81), .DI_1(di81), .WE_1(we81), .DQ_1(dq81),
        .CLR(clr8),
`ifdef IMAGE_BUFFER_COLL_FLAG_EN
        .COLL(coll8),
`endif
        .RDY(rdy8)
    );

    typedef struct packed {
        logic [DW-1:0] dq0;
        logic [DW-1:0] dq1;
        logic          rdy;
        logic          coll;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mem_m [DEPTH];
    int            clear_left;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // After any clear start the whole model memory is simply zero.
    task automatic model_reset();
        clear_left = DEPTH;
        foreach (mem_m[i]) mem_m[i] = '0;
        exp_q.delete();
    endtask

    task automatic step(input int a0, input int d0, input int w0,
                        input int a1, input int d1, input int w1, input int c);
        exp_t e;
        a0 = a0 % DEPTH;
        a1 = a1 % DEPTH;
        A_0  = a0[AW-1:0];
        DI_0 = d0[DW-1:0];
        WE_0 = w0[0];
        A_1  = a1[AW-1:0];
        DI_1 = d1[DW-1:0];
        WE_1 = w1[0];
        CLR  = c[0];
        e = '0;
        if (clear_left > 0) begin
            clear_left--;
            e.rdy = (clear_left == 0);
        end else if (c[0]) begin
            clear_left = DEPTH;
            foreach (mem_m[i]) mem_m[i] = '0;
        end else begin
            e.dq0  = mem_m[a0];
            e.dq1  = mem_m[a1];
            e.rdy  = 1'b1;
            e.coll = w0[0] && w1[0] && (a0 == a1);
            if (w1[0]) mem_m[a1] = d1[DW-1:0];
            if (w0[0]) mem_m[a0] = d0[DW-1:0];
        end
        exp_q.push_back(e);
        @(negedge CLK);
    endtask

    task automatic rstep(input int clr_chance);
        int lim;
        int c;
        lim = ($urandom_range(1) == 1) ? 3 : DEPTH - 1;
        c = (clr_chance > 0 && $urandom_range(clr_chance - 1) == 0) ? 1 : 0;
        step($urandom_range(lim), $urandom_range(1), $urandom_range(1),
             $urandom_range(lim), $urandom_range(1), $urandom_range(1), c);
    endtask

    task automatic async_reset_check();
        #2;
        RST_N = 1'b0;
        exp_q.delete();
        #1;
        check("rst_dq0", DQ_0, 0);
        check("rst_dq1", DQ_1, 0);
        check("rst_rdy", RDY, 0);
`ifdef IMAGE_BUFFER_COLL_FLAG_EN
        check("rst_coll", COLL, 0);
`endif
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dq0", DQ_0, e.dq0);
                check("dq1", DQ_1, e.dq1);
                check("rdy", RDY, e.rdy);
`ifdef IMAGE_BUFFER_COLL_FLAG_EN
                check("coll", COLL, e.coll);
`endif
            end
        end
    end

    initial begin : stimulus
        int cyc;
        RST_N = 1'b0; A_0 = '0; A_1 = '0; DI_0 = '0; DI_1 = '0;
        WE_0 = 1'b0; WE_1 = 1'b0; CLR = 1'b0;
        rst8 = 1'b0; a80 = '0; a81 = '0; di80 = '0; di81 = '0;
        we80 = 1'b0; we81 = 1'b0; clr8 = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        check("init_rdy", RDY, 0);
        check("init_dq0", DQ_0, 0);
        check("init_dq1", DQ_1, 0);
        RST_N = 1'b1;

        for (int i = 0; i < DEPTH; i++) rstep(4);
        for (int i = 0; i < DEPTH; i++) step(i, 0, 0, DEPTH - 1 - i, 0, 0, 0);

        step(7, 1, 1, 7, 0, 0, 0);
        step(0, 0, 0, 7, 0, 0, 0);
        step(12, 1, 1, 12, 0, 1, 0);
        step(12, 0, 0, 12, 0, 0, 0);
        step(7, 0, 0, 7, 0, 0, 0);
        async_reset_check();
        for (int i = 0; i < DEPTH; i++) step(i, 0, 0, 7, 0, 0, 0);
        step(12, 0, 0, 7, 0, 0, 0);

        for (int i = 0; i < DEPTH; i++) step(i, 1, 1, DEPTH - 1 - i, 1, 1, 0);
        step(3, 1, 1, 5, 1, 1, 1);
        for (int i = 0; i < DEPTH; i++) step(i, 0, 0, $urandom_range(DEPTH - 1), 1, 1, i % 2);
        for (int i = 0; i < DEPTH; i++) step(i, 0, 0, DEPTH - 1 - i, 0, 0, 0);

        for (int i = 0; i < DEPTH; i++) step(i, 1, 1, i, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) rstep(0);
        async_reset_check();
        for (int i = 0; i < DEPTH; i++) rstep(0);
        for (int i = 0; i < DEPTH; i++) step(i, 0, 0, DEPTH - 1 - i, 0, 0, 0);

        for (int i = 0; i < 1500; i++) rstep(64);
        repeat (3) @(negedge CLK);

        rst8 = 1'b1;
        cyc = 0;
        while (!rdy8 && cyc < 1000) begin
            cyc++;
            @(negedge CLK);
        end
        check("w8_reset_clear_cycles", cyc, 256);
        a81 = 8'd255; di81 = 8'hA5; we81 = 1'b1;
        @(negedge CLK);
        we81 = 1'b0; a80 = 8'd255;
        @(negedge CLK);
        check("w8_dq0_255", dq80, 8'hA5);
        clr8 = 1'b1;
        @(negedge CLK);
        clr8 = 1'b0;
        cyc = 0;
        while (!rdy8 && cyc < 1000) begin
            cyc++;
            @(negedge CLK);
        end
        check("w8_clr_clear_cycles", cyc, 256);
        @(negedge CLK);
        check("w8_dq0_255_cleared", dq80, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/image_buffer.md
IMAGE_BUFFER -- requirements
Module: image_buffer

Interface
REQ-001 The block SHALL have parameter A_W, default 5, address width; depth is 2**A_W words.
REQ-002 The block SHALL have parameter D_W, default 1, data word width.
REQ-003 The block SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port A_0  input  A_W  I/O-area port address.
REQ-006 The block SHALL have port DI_0  input  D_W  I/O-area write data.
REQ-007 The block SHALL have port WE_0  input  1  I/O-area write enable.
REQ-008 The block SHALL have port DQ_0  output  D_W  I/O-area registered read data.
REQ-009 The block SHALL have ports A_1, DI_1, WE_1 and DQ_1, with the same widths as A_0, DI_0, WE_0 and DQ_0, forming the exchange-area port.
REQ-010 The block SHALL have port CLR  input  1  single-cycle request to clear the whole memory.
REQ-011 The block SHALL have port RDY  output  1  high when the memory is accepting accesses.
REQ-012 The block SHALL have port COLL  output  1  write-collision flag; this port is present only under REQ-027.

Function
REQ-013 The state machine SHALL have states IDLE and CLEAR; RDY is 1 in IDLE and 0 in CLEAR.
REQ-014 In IDLE, each port SHALL register read data from its address with 1-cycle latency, read-first: a write to the same address on the same edge returns the old word.
REQ-015 In IDLE, WE_x=1 SHALL write DI_x to A_x on the same edge, for both ports independently.
REQ-016 When both ports write the same address on the same edge, port 0 SHALL win, and the port 1 data SHALL be discarded.
REQ-017 A read on one port that coincides with a write on the other port to the same address SHALL return the old word.
REQ-018 CLR=1 in IDLE SHALL enter CLEAR; port writes in that same cycle SHALL be ignored.
REQ-019 In CLEAR, an internal counter SHALL write zero to address 0, 1, ..., 2**A_W-1, one address per cycle, then return to IDLE; CLEAR therefore lasts exactly 2**A_W cycles.
REQ-020 In CLEAR, WE_0 and WE_1 SHALL be ignored, DQ_0 and DQ_1 SHALL be driven to 0, and CLR SHALL be ignored (the clear does not restart).
REQ-021 The clear counter SHALL be A_W bits wide; terminal count is all-ones, and it wraps to 0 on exit.
REQ-022 The first accepted write after a clear SHALL occur on the edge after RDY rises.

Reset
REQ-023 RST_N=0 SHALL asynchronously force the state to CLEAR, the counter to 0, DQ_0 and DQ_1 to 0, RDY to 0 and COLL to 0.
REQ-024 On RST_N release, the block SHALL perform a full clear (REQ-019) before RDY rises; memory contents are therefore all-zero 2**A_W cycles after reset.
REQ-025 A reset asserted mid-clear or mid-write SHALL restart the clear from address 0; any write in flight is not guaranteed.
REQ-026 The memory array itself SHALL NOT be reset directly, so that it infers block RAM.

Configuration
REQ-027 With macro IMAGE_BUFFER_COLL_FLAG_EN defined, COLL SHALL pulse high for exactly 1 cycle, on the edge after a same-address dual write in IDLE.
REQ-028 Without IMAGE_BUFFER_COLL_FLAG_EN, port COLL and its logic SHALL be absent; functional behaviour, including port-0 priority, is otherwise unchanged.

Verification
REQ-029 Reset scenario: A_W=5; release RST_N -> RDY=0 for 32 cycles, then 1; reads of addresses 0..31 on both ports return 0.
REQ-030 Write/read scenario: IDLE, WE_0=1, A_0=7, DI_0=1, then read A_1=7 -> DQ_1=1 one cycle after the read address is applied; a same-edge read returns the old 0.
REQ-031 Collision scenario: WE_0=WE_1=1, A_0=A_1=12, DI_0=1, DI_1=0 -> MEM[12]=1; with the macro, COLL=1 for exactly one cycle.
REQ-032 Clear scenario: fill memory with ones, pulse CLR -> RDY low for 32 cycles, WE_1 pulses during that time have no effect, DQ_x=0 throughout; all words read 0 afterwards.
REQ-033 Reset mid-clear scenario: assert RST_N=0 at clear cycle 10 -> outputs go to 0 immediately; after release, RDY=0 for a full 32 cycles.
REQ-034 Width scenario: A_W=8, D_W=8; write 0xA5 to 255 via port 1 -> port 0 reads 0xA5 at 255, and the clear after that takes 256 cycles.
